mmp_fifo_param: RTL

Parametrised synchronous single-clock FIFO for the MMP command path. It carries packed sound-chip write words from the producer side (SPI/host receive logic) to the player/sequencer that drains them. It replaces the fixed 24-bit × 2048 buffer with configurable width and depth. It adds full-depth usage (no sacrificed slot), occupancy level, an almost-full threshold, overflow/underflow protection with sticky error flags, synchronous flush, and a pop-data valid strobe.

---
 rtl/mmp_pkg.sv | 18 +
 rtl/mmp_fifo_ram.sv | 38 +++
 rtl/mmp_fifo_param.sv | 107 ++++++++++
 3 files changed

// File: rtl/mmp_pkg.sv
// rtl/mmp_pkg.sv - shared MMP command-path types and defaults
package mmp_pkg;

  localparam int MMP_DW = 24;
  localparam int MMP_AW = 11;

  // Packed sound-chip write word as carried through the command FIFO
  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] addr;
    logic [7:0] data;
  } mmp_word_t;

  function automatic mmp_word_t mmp_word_unpack(input logic [MMP_DW-1:0] raw);
    return mmp_word_t'(raw);
  endfunction

endpackage

// File: rtl/mmp_fifo_ram.sv
// rtl/mmp_fifo_ram.sv - simple dual-port RAM with registered, enabled read port
module mmp_fifo_ram
  import mmp_pkg::*;
#(
  parameter int DW = MMP_DW,
  parameter int AW = MMP_AW
) (
  input  logic          i_CLK,
  input  logic          i_RST_n,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge i_CLK) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Output register has its own reset so the read data starts at zero
  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mmp_fifo_param.sv
// rtl/mmp_fifo_param.sv - parametrised single-clock command FIFO with level and sticky errors
module mmp_fifo_param
  import mmp_pkg::*;
#(
  parameter int DW       = MMP_DW,
  parameter int AW       = MMP_AW,
  parameter int AFULL_TH = 2**AW - 16
) (
  input  logic          i_CLK,
  input  logic          i_RST_n,
  input  logic          i_FLUSH,
  input  logic          i_PUSH_S,
  input  logic [DW-1:0] i_PUSH_DT,
  input  logic          i_POP_S,
  output logic [DW-1:0] o_POP_DT,
  output logic          o_POP_VLD,
  output logic          o_EMPTY,
  output logic          o_FULLY,
  output logic          o_AFULL,
  output logic [AW:0]   o_LEVEL,
  output logic          o_OVF,
  output logic          o_UDF,
  input  logic          i_CLR_ERR
);

  localparam logic [AW:0]   DEPTH_LV = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   AFULL_LV = (AW+1)'(AFULL_TH);
  localparam logic [AW:0]   LV_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   level_q, level_d;
  logic          empty_q, full_q, afull_q;
  logic          ovf_q, ovf_d, udf_q, udf_d, vld_q;
  logic          push_acc, pop_acc;

  always_comb begin
    push_acc = i_PUSH_S && !full_q && !i_FLUSH;
    pop_acc  = i_POP_S && !empty_q && !i_FLUSH;
    wp_d     = wp_q;
    rp_d     = rp_q;
    level_d  = level_q;
    if (i_FLUSH) begin
      wp_d    = '0;
      rp_d    = '0;
      level_d = '0;
    end else begin
      if (push_acc) wp_d = wp_q + PTR_ONE;
      if (pop_acc)  rp_d = rp_q + PTR_ONE;
      case ({push_acc, pop_acc})
        2'b10:   level_d = level_q + LV_ONE;
        2'b01:   level_d = level_q - LV_ONE;
        default: level_d = level_q;
      endcase
    end
    // A new error event in the same cycle as a clear keeps the flag set
    ovf_d = (ovf_q && !i_CLR_ERR) || (i_PUSH_S && full_q && !i_FLUSH);
    udf_d = (udf_q && !i_CLR_ERR) || (i_POP_S && empty_q && !i_FLUSH);
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      empty_q <= (level_d == '0);
      full_q  <= (level_d == DEPTH_LV);
      afull_q <= (level_d >= AFULL_LV);
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      vld_q   <= pop_acc;
    end
  end

  mmp_fifo_ram #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .i_CLK    (i_CLK),
    .i_RST_n  (i_RST_n),
    .wr_en_i  (push_acc),
    .wr_addr_i(wp_q),
    .wr_data_i(i_PUSH_DT),
    .rd_en_i  (pop_acc),
    .rd_addr_i(rp_q),
    .rd_data_o(o_POP_DT)
  );

  assign o_POP_VLD = vld_q;
  assign o_EMPTY   = empty_q;
  assign o_FULLY   = full_q;
  assign o_AFULL   = afull_q;
  assign o_LEVEL   = level_q;
  assign o_OVF     = ovf_q;
  assign o_UDF     = udf_q;

endmodule
